// File: rtl/dataflow_pkg.sv
// Shared definitions for the dataflow buffer blocks.
//   DATA_WIDTH   default payload width
//   clog2        ceil(log2(value)), usable in constant expressions
//   ptr_width    bits needed to address 'depth' entries (at least 1)
//   count_width  bits needed to hold an occupancy of 0..depth
package dataflow_pkg;

    localparam int DATA_WIDTH = 32;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) r++;
        return r;
    endfunction

    function automatic int ptr_width(input int depth);
        return (depth < 2) ? 1 : clog2(depth);
    endfunction

    function automatic int count_width(input int depth);
        return clog2(depth + 1);
    endfunction

endpackage

// File: rtl/handshake_fifo_mem.sv
// Storage for handshake_fifo: depth x data_width register array.
//   clk, rst_n   clock, async active-low reset (read register only)
//   we/waddr/wdata   write port, committed on posedge
//   re/raddr         read enable/address; rdata updates on posedge when re=1
//   rdata            registered read data, holds between reads, 0 after reset
module handshake_fifo_mem
    import dataflow_pkg::*;
#(
    parameter int data_width = DATA_WIDTH,
    parameter int depth      = 4,
    parameter int ptr_w      = ptr_width(depth)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic [ptr_w-1:0]      waddr,
    input  logic [data_width-1:0] wdata,
    input  logic                  re,
    input  logic [ptr_w-1:0]      raddr,
    output logic [data_width-1:0] rdata
);

    // Storage is intentionally not reset; the controller never reads an
    // entry it has not written since reset.
    logic [data_width-1:0] mem_q [depth];
    logic [data_width-1:0] rdata_q, rdata_d;

    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
    end

    // Read samples the array before this edge's write lands, so a slot
    // written in the same cycle is never forwarded.
    always_comb begin
        rdata_d = rdata_q;
        if (re) rdata_d = mem_q[raddr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rdata_q <= '0;
        else        rdata_q <= rdata_d;
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/handshake_fifo.sv
// Elastic req/ack buffer between an operator output and its consumer.
// Pulls words upstream with req_l/ack_l, serves them downstream with
// req_r/ack_r, and reports occupancy and transfer statistics.
//   req_l/ack_l/din      upstream: request one word, ack pulse with data
//   req_r/ack_r/dout     downstream: request level, ack pulse, registered data
//   count, max_count     current occupancy and its high-water mark
//   push_total/pop_total accepted / delivered word counts (wrapping)
module handshake_fifo
    import dataflow_pkg::*;
#(
    parameter int data_width = DATA_WIDTH,
    parameter int depth      = 4,
    parameter int cnt_width  = 32
) (
    input  logic                          clk,
    input  logic                          rst_n,
    output logic                          req_l,
    input  logic                          ack_l,
    input  logic [data_width-1:0]         din,
    input  logic                          req_r,
    output logic                          ack_r,
    output logic [data_width-1:0]         dout,
    output logic [count_width(depth)-1:0] count,
    output logic [count_width(depth)-1:0] max_count,
    output logic [cnt_width-1:0]          push_total,
    output logic [cnt_width-1:0]          pop_total
);

    localparam int PW = ptr_width(depth);
    localparam int CW = count_width(depth);
    localparam logic [CW-1:0] FULL_C   = CW'(depth);
    localparam logic [PW-1:0] LAST_PTR = PW'(depth - 1);

    logic [PW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]        count_q, count_d, max_q, max_d;
    logic                 req_l_q, req_l_d, ack_r_q, ack_r_d;
    logic [cnt_width-1:0] push_total_q, push_total_d, pop_total_q, pop_total_d;
    logic                 push, pop;

    always_comb begin
        // An ack while full is a protocol violation: the word is dropped.
        push = ack_l && (count_q != FULL_C);
        // ~ack_r_q turns the request level into one pop per two cycles.
        pop  = req_r && !ack_r_q && (count_q != '0);

        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        push_total_d = push_total_q;
        pop_total_d  = pop_total_q;

        if (push) begin
            wr_ptr_d     = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PW'(1);
            push_total_d = push_total_q + cnt_width'(1);
        end
        if (pop) begin
            rd_ptr_d    = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PW'(1);
            pop_total_d = pop_total_q + cnt_width'(1);
        end

        count_d = count_q + CW'(push) - CW'(pop);
        max_d   = (count_d > max_q) ? count_d : max_q;
        // Decided on the current count: a push is what could fill us, and
        // a push always forces the one-cycle re-request gap anyway.
        req_l_d = !push && (count_q < FULL_C);
        ack_r_d = pop;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            max_q        <= '0;
            req_l_q      <= 1'b0;
            ack_r_q      <= 1'b0;
            push_total_q <= '0;
            pop_total_q  <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            max_q        <= max_d;
            req_l_q      <= req_l_d;
            ack_r_q      <= ack_r_d;
            push_total_q <= push_total_d;
            pop_total_q  <= pop_total_d;
        end
    end

    handshake_fifo_mem #(
        .data_width (data_width),
        .depth      (depth),
        .ptr_w      (PW)
    ) u_mem (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (push),
        .waddr (wr_ptr_q),
        .wdata (din),
        .re    (pop),
        .raddr (rd_ptr_q),
        .rdata (dout)
    );

    assign req_l      = req_l_q;
    assign ack_r      = ack_r_q;
    assign count      = count_q;
    assign max_count  = max_q;
    assign push_total = push_total_q;
    assign pop_total  = pop_total_q;

endmodule
